// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes, FSM state types and byte-strobe merge for the AXI-Lite register slave
package axi_lite_pkg;
  localparam int AXI_DATA_W = 32;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  function automatic logic [AXI_DATA_W-1:0] strb_merge(
    input logic [AXI_DATA_W-1:0] old_v,
    input logic [AXI_DATA_W-1:0] new_v,
    input logic [AXI_DATA_W/8-1:0] strb
  );
    logic [AXI_DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < AXI_DATA_W/8; i++) if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: register storage with byte-strobe write port and combinational indexed read
module axi_lite_reg_bank import axi_lite_pkg::*; #(
  parameter int DATA_W = AXI_DATA_W,
  parameter int NUM_REGS = 16,
  localparam int RI_W = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [RI_W-1:0]            widx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [RI_W-1:0]            ridx,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] regs
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else if (we) mem[widx] <= strb_merge(mem[widx], wdata, wstrb);
  end
  assign rdata = mem[ridx];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs[i*DATA_W +: DATA_W] = mem[i];
  end
endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI-Lite register bank slave; AXI_LITE_REG_STATUS_EN turns the last reg into a read-only view of status_i
module axi_lite_reg_slave import axi_lite_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = AXI_DATA_W,
  parameter int NUM_REGS = 16,
  localparam int STRB_W = DATA_W/8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic [2:0]                 awprot,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [STRB_W-1:0]          wstrb,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic [2:0]                 arprot,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
`ifdef AXI_LITE_REG_STATUS_EN
  input  logic [DATA_W-1:0]          status_i,
`endif
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int RI_W = $clog2(NUM_REGS);
`ifdef AXI_LITE_REG_STATUS_EN
  localparam int WR_REGS = NUM_REGS - 1;
`else
  localparam int WR_REGS = NUM_REGS;
`endif
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic aw_held, w_held, aw_hs, w_hs, ar_hs, have_aw, have_w, commit, w_ok, we, r_ok;
  logic [IDX_W-1:0] aw_idx_q, w_idx, r_idx;
  logic [DATA_W-1:0] wdata_q, w_data, bank_rdata, rd_val;
  logic [STRB_W-1:0] wstrb_q, w_strb;
  logic [NUM_REGS*DATA_W-1:0] bank_regs;
  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
  always_comb begin
    awready = wr_state == W_IDLE && !aw_held;
    wready = wr_state == W_IDLE && !w_held;
    bvalid = wr_state == W_RESP;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    have_aw = aw_held || aw_hs;
    have_w = w_held || w_hs;
    commit = have_aw && have_w;
    w_idx = aw_held ? aw_idx_q : awaddr[ADDR_W-1:2];
    w_data = w_held ? wdata_q : wdata;
    w_strb = w_held ? wstrb_q : wstrb;
    w_ok = {1'b0, w_idx} < (IDX_W+1)'(WR_REGS);
    we = commit && w_ok;
    wr_next = commit ? W_RESP : (bvalid && bready) ? W_IDLE : wr_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp <= RESP_OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_state <= wr_next;
      aw_held <= have_aw && !commit;
      w_held <= have_w && !commit;
      if (aw_hs) aw_idx_q <= awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
      wr_pulse_o <= NUM_REGS'(we) << w_idx[RI_W-1:0];
    end
  end
  always_comb begin
    arready = rd_state == R_IDLE;
    rvalid = rd_state == R_DATA;
    ar_hs = arvalid && arready;
    r_idx = araddr[ADDR_W-1:2];
    r_ok = {1'b0, r_idx} < (IDX_W+1)'(NUM_REGS);
    rd_next = ar_hs ? R_DATA : (rvalid && rready) ? R_IDLE : rd_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rdata <= r_ok ? rd_val : '0;
        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
`ifdef AXI_LITE_REG_STATUS_EN
  assign rd_val = r_idx == IDX_W'(NUM_REGS-1) ? status_i : bank_rdata;
  always_comb begin
    regs_o = bank_regs;
    regs_o[(NUM_REGS-1)*DATA_W +: DATA_W] = status_i;
  end
`else
  assign rd_val = bank_rdata;
  assign regs_o = bank_regs;
`endif
  axi_lite_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_bank (
    .clk(clk),
    .rst(rst),
    .we(we),
    .widx(w_idx[RI_W-1:0]),
    .wdata(w_data),
    .wstrb(w_strb),
    .ridx(r_idx[RI_W-1:0]),
    .rdata(bank_rdata),
    .regs(bank_regs)
  );
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: directed scoreboard bench for axi_lite_reg_slave, status checks under AXI_LITE_REG_STATUS_EN
module tb_axi_lite_reg_slave;
  logic clk = 0, rst = 1;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [7:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic [31:0] wdata = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic [511:0] regs_o;
  logic [15:0] wr_pulse_o;
`ifdef AXI_LITE_REG_STATUS_EN
  logic [31:0] status_i = 32'hCAFE0001;
`endif
  int vectors = 0, miscompares = 0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  always #5 clk = ~clk;
  axi_lite_reg_slave dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
`ifdef AXI_LITE_REG_STATUS_EN
    .status_i(status_i),
`endif
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );
  function automatic logic [31:0] reg_at(input int i);
    return regs_o[i*32 +: 32];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_same(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] e);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    bq.push_back(e);
    tick();
    awvalid = 0; wvalid = 0;
  endtask
  task automatic rd(input logic [7:0] a, input logic [1:0] er, input logic [31:0] ed);
    arvalid = 1; araddr = a;
    rq.push_back({er, ed});
    tick();
    arvalid = 0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        vectors++;
        if (bq.size() == 0) begin
          miscompares++;
          $display("FAIL bresp: unexpected response %0h", bresp);
        end else begin
          logic [1:0] e;
          e = bq.pop_front();
          if (bresp !== e) begin
            miscompares++;
            $display("FAIL bresp: got %0h expected %0h", bresp, e);
          end
        end
      end
      if (rvalid && rready) begin
        vectors++;
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL rresp: unexpected read %0h/%0h", rresp, rdata);
        end else begin
          logic [33:0] e;
          e = rq.pop_front();
          if ({rresp, rdata} !== e) begin
            miscompares++;
            $display("FAIL rresp_rdata: got %0h/%0h expected %0h/%0h", rresp, rdata, e[33:32], e[31:0]);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_pulse", wr_pulse_o, 0);
    for (int i = 0; i < 15; i++) chk("rst_reg", reg_at(i), 0);
    awvalid = 1; awaddr = 8'h04; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    bq.push_back(2'b00);
    chk("t1_bvalid_pre", bvalid, 0);
    tick();
    awvalid = 0; wvalid = 0;
    chk("t1_bvalid", bvalid, 1);
    chk("t1_reg1", reg_at(1), 32'hDEADBEEF);
    chk("t1_pulse", wr_pulse_o, 16'h0002);
    chk("t1_awready_busy", awready, 0);
    tick();
    chk("t1_bvalid_done", bvalid, 0);
    chk("t1_pulse_off", wr_pulse_o, 0);
    chk("t1_awready_back", awready, 1);
    wr_same(8'h08, 32'hAAAAAAAA, 4'hF, 2'b00);
    tick();
    bready = 0;
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'h3;
    tick();
    wvalid = 0;
    chk("t2_wready_held", wready, 0);
    chk("t2_awready_open", awready, 1);
    chk("t2_reg2_pre", reg_at(2), 32'hAAAAAAAA);
    tick();
    chk("t2_wready_held2", wready, 0);
    awvalid = 1; awaddr = 8'h08;
    bq.push_back(2'b00);
    tick();
    awvalid = 0;
    chk("t2_reg2", reg_at(2), 32'hAAAA5678);
    chk("t2_bvalid", bvalid, 1);
    chk("t2_pulse", wr_pulse_o, 16'h0004);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_bvalid_hold", bvalid, 1);
      chk("t2_wready_wait", wready, 0);
      chk("t2_pulse_off", wr_pulse_o, 0);
    end
    bready = 1;
    tick();
    chk("t2_bvalid_done", bvalid, 0);
    chk("t2_wready_back", wready, 1);
    rready = 0;
    rd(8'h04, 2'b00, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rvalid", rvalid, 1);
      chk("t3_rdata", rdata, 32'hDEADBEEF);
      chk("t3_arready", arready, 0);
      tick();
    end
    rready = 1;
    tick();
    chk("t3_rvalid_done", rvalid, 0);
    chk("t3_arready_back", arready, 1);
    wr_same(8'h40, 32'h11111111, 4'hF, 2'b10);
    chk("t4_pulse", wr_pulse_o, 0);
    chk("t4_reg0", reg_at(0), 0);
    chk("t4_reg1", reg_at(1), 32'hDEADBEEF);
    tick();
    rd(8'h40, 2'b10, 32'h0);
    tick();
    wr_same(8'h04, 32'hFFFFFFFF, 4'h0, 2'b00);
    chk("t5_pulse", wr_pulse_o, 16'h0002);
    chk("t5_reg1", reg_at(1), 32'hDEADBEEF);
    tick();
    wr_same(8'h0F, 32'h0BADF00D, 4'hF, 2'b00);
    chk("t6_reg3", reg_at(3), 32'h0BADF00D);
    tick();
    rd(8'h0E, 2'b00, 32'h0BADF00D);
    tick();
    awvalid = 1; awaddr = 8'h04; wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
    arvalid = 1; araddr = 8'h04;
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'hDEADBEEF});
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t7_reg1", reg_at(1), 32'h55AA55AA);
    chk("t7_rvalid", rvalid, 1);
    chk("t7_bvalid", bvalid, 1);
    tick();
`ifdef AXI_LITE_REG_STATUS_EN
    chk("t8_regs_status", reg_at(15), 32'hCAFE0001);
    rd(8'h3C, 2'b00, 32'hCAFE0001);
    tick();
    wr_same(8'h3C, 32'h12345678, 4'hF, 2'b10);
    chk("t8_pulse", wr_pulse_o, 0);
    chk("t8_reg15", reg_at(15), 32'hCAFE0001);
    tick();
`else
    wr_same(8'h3C, 32'h13579BDF, 4'hF, 2'b00);
    chk("t8_pulse", wr_pulse_o, 16'h8000);
    chk("t8_reg15", reg_at(15), 32'h13579BDF);
    tick();
    rd(8'h3C, 2'b00, 32'h13579BDF);
    tick();
`endif
    bready = 0;
    wr_same(8'h10, 32'h44444444, 4'hF, 2'b00);
    void'(bq.pop_back());
    chk("t9_bvalid_pre", bvalid, 1);
    chk("t9_reg4", reg_at(4), 32'h44444444);
    rst = 1;
    tick();
    rst = 0;
    bready = 1;
    chk("t9_bvalid", bvalid, 0);
    chk("t9_awready", awready, 1);
    chk("t9_wready", wready, 1);
    chk("t9_reg1", reg_at(1), 0);
    chk("t9_reg2", reg_at(2), 0);
    chk("t9_reg4", reg_at(4), 0);
    tick(); tick();
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
